// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, output colour struct and colour-expansion helper
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam int OUT_W_DEF = 4;
  localparam int MAXW = 16;
  typedef struct packed {
    logic [OUT_W_DEF-1:0] r;
    logic [OUT_W_DEF-1:0] g;
    logic [OUT_W_DEF-1:0] b;
  } rgb_out_t;
  // Repeats the in_w-bit value MSB-first until out_w bits are covered, keeps the top out_w bits.
  function automatic logic [MAXW-1:0] expand_color(input logic [MAXW-1:0] in, input int in_w,
                                                   input int out_w);
    logic [2*MAXW-1:0] acc;
    int l;
    acc = '0;
    l = 0;
    for (int i = 0; i < MAXW; i++)
      if (l < out_w) begin
        acc = (acc << in_w) | {{MAXW{1'b0}}, in};
        l += in_w;
      end
    return MAXW'(acc >> (l - out_w)) & ({MAXW{1'b1}} >> (MAXW - out_w));
  endfunction
endpackage

// File: rtl/vga_timing_pipe_if.sv
// vga_timing_pipe_if: pixel request / colour return link between timing pipe and graphics
interface vga_timing_pipe_if #(
  parameter int CNT_W = 10,
  parameter int R_IN_W = 3,
  parameter int G_IN_W = 3,
  parameter int B_IN_W = 2
);
  logic [CNT_W-1:0] req_x;
  logic [CNT_W-1:0] req_y;
  logic req_valid;
  logic sof;
  logic eol;
  logic [R_IN_W-1:0] in_red;
  logic [G_IN_W-1:0] in_green;
  logic [B_IN_W-1:0] in_blue;
  modport master (output req_x, req_y, req_valid, sof, eol, input in_red, in_green, in_blue);
  modport slave (input req_x, req_y, req_valid, sof, eol, output in_red, in_green, in_blue);
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register with reset value RST; DEPTH==0 is a plain wire
module vga_delay_line #(
  parameter int W = 1,
  parameter int DEPTH = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         vgaclk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = vgaclk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_reg
    logic [W-1:0] sr_q [DEPTH];
    always_ff @(posedge vgaclk) begin
      if (!rst_n) sr_q <= '{default: RST};
      else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end
    assign q_o = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: VGA timing generator issuing pixel requests PIX_LAT ahead, realigned sync/colour outputs.
// Optional colour-bar test pattern with test_en port when VGA_TESTPAT_EN is defined.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = H_ACTIVE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_ACTIVE  = V_ACTIVE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   R_IN_W    = 3,
  parameter int   G_IN_W    = 3,
  parameter int   B_IN_W    = 2,
  parameter int   OUT_W     = OUT_W_DEF,
  parameter int   PIX_LAT   = 1,
  parameter int   CNT_W     = 10
) (
  input  logic             vgaclk,
  input  logic             rst_n,
`ifdef VGA_TESTPAT_EN
  input  logic             test_en,
`endif
  vga_timing_pipe_if.master gfx,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [OUT_W-1:0] red,
  output logic [OUT_W-1:0] green,
  output logic [OUT_W-1:0] blue
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_B = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_B = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_cnt_err
    $error("vga_timing_pipe: H/V total exceeds counter range");
  end
  if (R_IN_W == 0 || G_IN_W == 0 || B_IN_W == 0 || R_IN_W > OUT_W || G_IN_W > OUT_W ||
      B_IN_W > OUT_W || OUT_W > MAXW) begin : g_w_err
    $error("vga_timing_pipe: illegal colour widths");
  end
  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic h_wrap;
  always_comb begin
    h_wrap = hc_q == H_MAX;
    hc_d = h_wrap ? '0 : hc_q + 1'b1;
    vc_d = !h_wrap ? vc_q : (vc_q == V_MAX ? '0 : vc_q + 1'b1);
  end
  always_ff @(posedge vgaclk) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end
  assign gfx.req_x = hc_q;
  assign gfx.req_y = vc_q;
  assign gfx.req_valid = hc_q < H_ACT && vc_q < V_ACT;
  assign gfx.sof = hc_q == '0 && vc_q == '0;
  assign gfx.eol = h_wrap;
  logic [2:0] ctl_s0, ctl_dly;
  always_comb begin
    ctl_s0[2] = gfx.req_valid;
    ctl_s0[1] = (hc_q >= HS_B && hc_q < HS_E) ? HSYNC_POL : ~HSYNC_POL;
    ctl_s0[0] = (vc_q >= VS_B && vc_q < VS_E) ? VSYNC_POL : ~VSYNC_POL;
  end
  // Control travels alongside the graphics latency so it meets the returned colour.
  vga_delay_line #(.W(3), .DEPTH(PIX_LAT), .RST({1'b0, ~HSYNC_POL, ~VSYNC_POL})) u_ctl (
    .vgaclk(vgaclk),
    .rst_n (rst_n),
    .d_i   (ctl_s0),
    .q_o   (ctl_dly)
  );
  logic [OUT_W-1:0] r_px, g_px, b_px;
`ifdef VGA_TESTPAT_EN
  logic [CNT_W-1:0] x_dly;
  logic [2:0] bar;
  vga_delay_line #(.W(CNT_W), .DEPTH(PIX_LAT)) u_x (
    .vgaclk(vgaclk),
    .rst_n (rst_n),
    .d_i   (hc_q),
    .q_o   (x_dly)
  );
  assign bar = 3'(x_dly / CNT_W'(H_ACTIVE / 8));
  always_comb begin
    r_px = test_en ? {OUT_W{bar[2]}} : OUT_W'(expand_color(MAXW'(gfx.in_red), R_IN_W, OUT_W));
    g_px = test_en ? {OUT_W{bar[1]}} : OUT_W'(expand_color(MAXW'(gfx.in_green), G_IN_W, OUT_W));
    b_px = test_en ? {OUT_W{bar[0]}} : OUT_W'(expand_color(MAXW'(gfx.in_blue), B_IN_W, OUT_W));
  end
`else
  always_comb begin
    r_px = OUT_W'(expand_color(MAXW'(gfx.in_red), R_IN_W, OUT_W));
    g_px = OUT_W'(expand_color(MAXW'(gfx.in_green), G_IN_W, OUT_W));
    b_px = OUT_W'(expand_color(MAXW'(gfx.in_blue), B_IN_W, OUT_W));
  end
`endif
  logic hsync_q, vsync_q, de_q;
  logic [3*OUT_W-1:0] rgb_q, rgb_d;
  always_comb rgb_d = ctl_dly[2] ? {r_px, g_px, b_px} : '0;
  always_ff @(posedge vgaclk) begin
    if (!rst_n) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hsync_q <= ctl_dly[1];
      vsync_q <= ctl_dly[0];
      de_q <= ctl_dly[2];
      rgb_q <= rgb_d;
    end
  end
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de = de_q;
  assign {red, green, blue} = rgb_q;
endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe: directed checks of timing, latency, colour expansion and reset on three configurations
module tb_vga_timing_pipe;
  logic vgaclk = 1'b0;
  logic rst_n = 1'b0;
  logic te = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 vgaclk = ~vgaclk;
  vga_timing_pipe_if #(.CNT_W(10)) if0 ();
  vga_timing_pipe_if #(.CNT_W(10)) if1 ();
  vga_timing_pipe_if #(.CNT_W(5)) if2 ();
  logic hs0, vs0, de0, hs1, vs1, de1, hs2, vs2, de2;
  logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
  vga_timing_pipe u0 (
    .vgaclk(vgaclk), .rst_n(rst_n),
`ifdef VGA_TESTPAT_EN
    .test_en(te),
`endif
    .gfx(if0), .hsync(hs0), .vsync(vs0), .de(de0), .red(r0), .green(g0), .blue(b0)
  );
  vga_timing_pipe #(.PIX_LAT(3), .HSYNC_POL(1'b1)) u1 (
    .vgaclk(vgaclk), .rst_n(rst_n),
`ifdef VGA_TESTPAT_EN
    .test_en(1'b0),
`endif
    .gfx(if1), .hsync(hs1), .vsync(vs1), .de(de1), .red(r1), .green(g1), .blue(b1)
  );
  vga_timing_pipe #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
                    .V_SYNC(2), .V_BP(2), .PIX_LAT(2), .CNT_W(5)) u2 (
    .vgaclk(vgaclk), .rst_n(rst_n),
`ifdef VGA_TESTPAT_EN
    .test_en(1'b0),
`endif
    .gfx(if2), .hsync(hs2), .vsync(vs2), .de(de2), .red(r2), .green(g2), .blue(b2)
  );
  logic [7:0] c1_q [3];
  always @(posedge vgaclk) begin
    c1_q[0] <= {if1.req_x[2:0], if1.req_y[2:0], if1.req_x[4:3]};
    c1_q[1] <= c1_q[0];
    c1_q[2] <= c1_q[1];
  end
  assign if1.in_red = c1_q[2][7:5];
  assign if1.in_green = c1_q[2][4:2];
  assign if1.in_blue = c1_q[2][1:0];
  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    int de_rise0, de_rise1, hs_fall0, hs_rise1, low0, low0_all, high1;
    int sof2, vs_fall2, vlow2, eol2, hlow2, w;
    if0.in_red = 3'b101;
    if0.in_green = 3'b101;
    if0.in_blue = 2'b10;
    if2.in_red = 3'b111;
    if2.in_green = 3'b111;
    if2.in_blue = 2'b11;
    de_rise0 = -1; de_rise1 = -1; hs_fall0 = -1; hs_rise1 = -1;
    low0 = 0; low0_all = 0; high1 = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_hs0", hs0, 1);
    chk("rst_vs0", vs0, 1);
    chk("rst_de0", de0, 0);
    chk("rst_rgb0", {r0, g0, b0}, 0);
    chk("rst_hs1", hs1, 0);
    chk("rst_req0", {if0.req_y, if0.req_x}, 0);
    rst_n = 1'b1;
    chk("rel_sof0", if0.sof, 1);
    chk("rel_valid0", if0.req_valid, 1);
    for (int n = 1; n <= 1610; n++) begin
      tick();
      if (de0 && de_rise0 < 0) de_rise0 = n;
      if (de1 && de_rise1 < 0) de_rise1 = n;
      if (!hs0 && hs_fall0 < 0) hs_fall0 = n;
      if (hs1 && hs_rise1 < 0) hs_rise1 = n;
      if (!hs0 && n <= 800) low0++;
      if (!hs0) low0_all++;
      if (hs1 && n <= 800) high1++;
      if (n == 1) chk("fill_de0", de0, 0);
      if (n == 1) chk("fill_hs0", hs0, 1);
      if (n == 2) chk("px0_rgb0", {r0, g0, b0}, 12'hBBA);
      if (n == 3) chk("fill_de1", de1, 0);
      if (n == 9) chk("px5_rgb1", {r1, g1, b1}, 12'hB00);
      if (n == 17) chk("px13_rgb1", {r1, g1, b1}, 12'hB05);
      if (n == 641) chk("px639_rgb0", {de0, r0, g0, b0}, 13'h1BBA);
      if (n == 642) chk("px640_blank0", {de0, r0, g0, b0}, 0);
      if (n == 799) chk("eol0", if0.eol, 1);
      if (n == 800) chk("line1_req0", {if0.sof, if0.req_y, if0.req_x}, 21'h400);
      if (n == 806) chk("l1px2_rgb1", {de1, r1, g1, b1}, 13'h1420);
      if (n == 1600) chk("vs0_idle", vs0, 1);
    end
    chk("de_rise0", de_rise0, 2);
    chk("de_rise1", de_rise1, 4);
    chk("hs_fall0", hs_fall0, 658);
    chk("hs_low0", low0, 96);
    chk("hs_low0_2l", low0_all, 192);
    chk("hs_rise1", hs_rise1, 660);
    chk("hs_high1", high1, 96);
    sof2 = -1; vs_fall2 = -1; vlow2 = 0; eol2 = 0; hlow2 = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rel_sof2", if2.sof, 1);
    for (int n = 1; n <= 700; n++) begin
      tick();
      if (if2.sof && sof2 < 0) sof2 = n;
      if (!vs2 && vs_fall2 < 0) vs_fall2 = n;
      if (n <= 275 && !vs2) vlow2++;
      if (n <= 275 && !hs2) hlow2++;
      if (n <= 275 && if2.eol) eol2++;
      if (n == 2) chk("fill_de2", de2, 0);
      if (n == 3) chk("px0_rgb2", {de2, r2, g2, b2}, 13'h1FFF);
    end
    chk("frame2", sof2, 275);
    chk("vs_fall2", vs_fall2, 178);
    chk("vs_low2", vlow2, 50);
    chk("hs_low2", hlow2, 44);
    chk("eol_cnt2", eol2, 11);
    w = 0;
    while (!(if2.req_x == 5'd10 && if2.req_y == 5'd4) && w < 400) begin
      tick();
      w++;
    end
    chk("find_mid2", {if2.req_y, if2.req_x}, {5'd4, 5'd10});
    chk("pre_rst_de2", de2, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_req2", {if2.sof, if2.req_y, if2.req_x}, 11'h400);
    chk("mid_pins2", {hs2, vs2, de2, r2, g2, b2}, 15'h6000);
    tick();
    chk("mid_n1_de2", {hs2, de2}, 2'b10);
    tick();
    chk("mid_n2_de2", de2, 0);
    tick();
    chk("mid_n3_rgb2", {de2, r2, g2, b2}, 13'h1FFF);
    for (int n = 4; n <= 275; n++) tick();
    chk("mid_sof2", {if2.sof, if2.req_y, if2.req_x}, 11'h400);
`ifdef VGA_TESTPAT_EN
    te = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 650; n++) begin
      tick();
      if (n == 2) chk("bar_x0", {r0, g0, b0}, 12'h000);
      if (n == 82) chk("bar_x80", {r0, g0, b0}, 12'h00F);
      if (n == 641) chk("bar_x639", {r0, g0, b0}, 12'hFFF);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
